// File: rtl/regfile_pkg.sv
// Shared types and helpers for the 2-write / 2-read register file.
// Imported by the top level and by the read-port slice.
package regfile_pkg;

  typedef enum logic [1:0] {
    SRC_ARRAY,
    SRC_BYP0,
    SRC_BYP1,
    SRC_ZERO
  } rd_src_e;

  // A 2-entry file still needs one address bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: range check, write bypass, valid flag
// and hold-or-clear behaviour when the port is idle.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1,
  parameter bit HOLD     = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [AW-1:0]               rda,
  input  logic                        enr,
  input  logic [AW-1:0]               wra0,
  input  logic                        enw0,
  input  logic [WIDTH-1:0]            d0,
  input  logic [AW-1:0]               wra1,
  input  logic                        enw1,
  input  logic [WIDTH-1:0]            d1,
  output logic [WIDTH-1:0]            q,
  output logic                        v
);

  logic       in_range;
  logic       is_zero;
  logic       hit0;
  logic       hit1;
  logic       sel_zero;
  logic       sel_b1;
  logic       sel_b0;
  rd_src_e    src;
  logic [WIDTH-1:0] rd_data;

  assign in_range = {1'b0, rda} < (AW+1)'(DEPTH);
  assign is_zero  = ZERO_REG && (rda == '0);
  assign hit0     = BYPASS && enw0 && (wra0 == rda);
  assign hit1     = BYPASS && enw1 && (wra1 == rda);

  // Priority flattened into disjoint selects: zero, then port 1.
  assign sel_zero = !in_range || is_zero;
  assign sel_b1   = !sel_zero && hit1;
  assign sel_b0   = !sel_zero && !hit1 && hit0;

  always_comb begin
    src = SRC_ARRAY;
    unique case (1'b1)
      sel_zero: src = SRC_ZERO;
      sel_b1:   src = SRC_BYP1;
      sel_b0:   src = SRC_BYP0;
      default:  src = SRC_ARRAY;
    endcase
  end

  always_comb begin
    rd_data = '0;
    unique case (src)
      SRC_ARRAY: rd_data = regs[rda];
      SRC_BYP0:  rd_data = d0;
      SRC_BYP1:  rd_data = d1;
      SRC_ZERO:  rd_data = '0;
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      v <= 1'b0;
    end else if (enr) begin
      q <= rd_data;
      v <= 1'b1;
    end else begin
      v <= 1'b0;
      if (!HOLD) q <= '0;
    end
  end

endmodule

// File: rtl/regfile_2w2r.sv
// DEPTH x WIDTH register file with two write and two registered
// read ports; write port 1 wins an address collision.
module regfile_2w2r
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int DEPTH    = 4,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1,
  parameter bit HOLD     = 1'b1,
  localparam int AW      = clog2_min1(DEPTH)
) (
  input  logic             Clkb,
  input  logic             Rst,
  input  logic [WIDTH-1:0] D0,
  input  logic [AW-1:0]    WRA0,
  input  logic             ENW0,
  input  logic [WIDTH-1:0] D1,
  input  logic [AW-1:0]    WRA1,
  input  logic             ENW1,
  input  logic [AW-1:0]    RDA0,
  input  logic             ENR0,
  input  logic [AW-1:0]    RDA1,
  input  logic             ENR1,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic             V0,
  output logic             V1
);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic                        wok0;
  logic                        wok1;

  assign wok0 = ENW0
    && ({1'b0, WRA0} < (AW+1)'(DEPTH))
    && !(ZERO_REG && (WRA0 == '0));
  assign wok1 = ENW1
    && ({1'b0, WRA1} < (AW+1)'(DEPTH))
    && !(ZERO_REG && (WRA1 == '0));

  // Port 1 is assigned last so it overrides port 0 on a collision.
  always_ff @(posedge Clkb) begin
    if (Rst) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wok0 && (WRA0 == AW'(i))) regs[i] <= D0;
        if (wok1 && (WRA1 == AW'(i))) regs[i] <= D1;
      end
    end
  end

  regfile_read_port #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .AW      (AW),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS),
    .HOLD    (HOLD)
  ) u_rd0 (
    .clk (Clkb),
    .rst (Rst),
    .regs(regs),
    .rda (RDA0),
    .enr (ENR0),
    .wra0(WRA0),
    .enw0(ENW0),
    .d0  (D0),
    .wra1(WRA1),
    .enw1(ENW1),
    .d1  (D1),
    .q   (Q0),
    .v   (V0)
  );

  regfile_read_port #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .AW      (AW),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS),
    .HOLD    (HOLD)
  ) u_rd1 (
    .clk (Clkb),
    .rst (Rst),
    .regs(regs),
    .rda (RDA1),
    .enr (ENR1),
    .wra0(WRA0),
    .enw0(ENW0),
    .d0  (D0),
    .wra1(WRA1),
    .enw1(ENW1),
    .d1  (D1),
    .q   (Q1),
    .v   (V1)
  );

endmodule

// File: tb/tb_regfile_2w2r.sv
// Bench for regfile_2w2r: instance 0 uses defaults, instance 1 uses
// DEPTH=6, ZERO_REG=1, BYPASS=0, HOLD=0; both run against one model.
module tb_regfile_2w2r;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Inputs indexed [dut][port]; instance 0 uses the low 2 address bits.
  logic [9:0] d   [2][2];
  logic [2:0] wra [2][2];
  logic       enw [2][2];
  logic [2:0] rda [2][2];
  logic       enr [2][2];

  logic [9:0] qa0, qa1, qb0, qb1;
  logic       va0, va1, vb0, vb1;
  logic [9:0] dq [2][2];
  logic       dv [2][2];

  assign dq[0][0] = qa0;
  assign dq[0][1] = qa1;
  assign dq[1][0] = qb0;
  assign dq[1][1] = qb1;
  assign dv[0][0] = va0;
  assign dv[0][1] = va1;
  assign dv[1][0] = vb0;
  assign dv[1][1] = vb1;

  regfile_2w2r u_a (
    .Clkb(clk), .Rst(rst),
    .D0(d[0][0]), .WRA0(wra[0][0][1:0]), .ENW0(enw[0][0]),
    .D1(d[0][1]), .WRA1(wra[0][1][1:0]), .ENW1(enw[0][1]),
    .RDA0(rda[0][0][1:0]), .ENR0(enr[0][0]),
    .RDA1(rda[0][1][1:0]), .ENR1(enr[0][1]),
    .Q0(qa0), .Q1(qa1), .V0(va0), .V1(va1)
  );

  regfile_2w2r #(
    .WIDTH(10), .DEPTH(6), .ZERO_REG(1'b1),
    .BYPASS(1'b0), .HOLD(1'b0)
  ) u_b (
    .Clkb(clk), .Rst(rst),
    .D0(d[1][0]), .WRA0(wra[1][0]), .ENW0(enw[1][0]),
    .D1(d[1][1]), .WRA1(wra[1][1]), .ENW1(enw[1][1]),
    .RDA0(rda[1][0]), .ENR0(enr[1][0]),
    .RDA1(rda[1][1]), .ENR1(enr[1][1]),
    .Q0(qb0), .Q1(qb1), .V0(vb0), .V1(vb1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [9:0] mem [2][8];
  logic [9:0] eq  [2][2];
  logic       ev  [2][2];

  function automatic int cfg_depth(int c); return c ? 6 : 4; endfunction
  function automatic bit cfg_zr(int c);    return c != 0;    endfunction
  function automatic bit cfg_byp(int c);   return c == 0;    endfunction
  function automatic bit cfg_hold(int c);  return c == 0;    endfunction

  function automatic logic [9:0] read_val(int c, int p);
    int a;
    a = int'(rda[c][p]);
    if (a >= cfg_depth(c) || (cfg_zr(c) && a == 0)) return 10'h000;
    if (cfg_byp(c) && enw[c][1] && int'(wra[c][1]) == a) return d[c][1];
    if (cfg_byp(c) && enw[c][0] && int'(wra[c][0]) == a) return d[c][0];
    return mem[c][a];
  endfunction

  task automatic model_step();
    int a;
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) mem[c][i] = '0;
        for (int p = 0; p < 2; p++) begin
          eq[c][p] = '0;
          ev[c][p] = 1'b0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (enr[c][p]) begin
            eq[c][p] = read_val(c, p);
            ev[c][p] = 1'b1;
          end else begin
            ev[c][p] = 1'b0;
            if (!cfg_hold(c)) eq[c][p] = '0;
          end
        end
        for (int p = 0; p < 2; p++) begin
          a = int'(wra[c][p]);
          if (enw[c][p] && a < cfg_depth(c) && !(cfg_zr(c) && a == 0))
            mem[c][a] = d[c][p];
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0;
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < 2; p++) begin
        enw[c][p] = 1'b0;
        enr[c][p] = 1'b0;
        d[c][p]   = '0;
        wra[c][p] = '0;
        rda[c][p] = '0;
      end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    enw[0][0] = 1'b1; wra[0][0] = 3'd1; d[0][0] = 10'h155;
    enr[0][1] = 1'b1; enr[1][0] = 1'b1;
    tick();
    idle();
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < 2; p++) begin
        n_cmp++;
        if (dq[c][p] !== 10'h000) begin
          n_bad++;
          $display("FAIL reset_q dut%0d p%0d got %h want 000", c, p, dq[c][p]);
        end
        n_cmp++;
        if (dv[c][p] !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_v dut%0d p%0d got %b want 0", c, p, dv[c][p]);
        end
      end
  endtask

  task automatic test_basic();
    idle();
    enw[0][0] = 1'b1; wra[0][0] = 3'd2; d[0][0] = 10'h2A5;
    tick();
    idle();
    enr[0][0] = 1'b1; rda[0][0] = 3'd2;
    tick();
    idle();
    n_cmp++;
    if (qa0 !== 10'h2A5) begin
      n_bad++;
      $display("FAIL basic_q0 got %h want 2a5", qa0);
    end
    n_cmp++;
    if (va0 !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_v0 got %b want 1", va0);
    end
  endtask

  task automatic test_collision();
    idle();
    enw[0][0] = 1'b1; wra[0][0] = 3'd1; d[0][0] = 10'h111;
    enw[0][1] = 1'b1; wra[0][1] = 3'd1; d[0][1] = 10'h222;
    tick();
    idle();
    enr[0][0] = 1'b1; rda[0][0] = 3'd1;
    enr[0][1] = 1'b1; rda[0][1] = 3'd1;
    tick();
    idle();
    n_cmp++;
    if (qa0 !== 10'h222) begin
      n_bad++;
      $display("FAIL collide_q0 got %h want 222", qa0);
    end
    n_cmp++;
    if (qa1 !== 10'h222) begin
      n_bad++;
      $display("FAIL collide_q1 got %h want 222", qa1);
    end
  endtask

  task automatic test_bypass();
    idle();
    for (int c = 0; c < 2; c++) begin
      enw[c][0] = 1'b1; wra[c][0] = 3'd3; d[c][0] = 10'h055;
    end
    tick();
    idle();
    for (int c = 0; c < 2; c++) begin
      enw[c][0] = 1'b1; wra[c][0] = 3'd3; d[c][0] = 10'h3FF;
      enr[c][1] = 1'b1; rda[c][1] = 3'd3;
    end
    tick();
    idle();
    n_cmp++;
    if (qa1 !== 10'h3FF) begin
      n_bad++;
      $display("FAIL bypass_on_q1 got %h want 3ff", qa1);
    end
    n_cmp++;
    if (qb1 !== 10'h055) begin
      n_bad++;
      $display("FAIL bypass_off_q1 got %h want 055", qb1);
    end
    enr[1][1] = 1'b1; rda[1][1] = 3'd3;
    tick();
    idle();
    n_cmp++;
    if (qb1 !== 10'h3FF) begin
      n_bad++;
      $display("FAIL bypass_off_next got %h want 3ff", qb1);
    end
  endtask

  task automatic test_hold();
    idle();
    for (int c = 0; c < 2; c++) begin
      enw[c][0] = 1'b1; wra[c][0] = 3'd2; d[c][0] = 10'h2A5;
    end
    tick();
    idle();
    for (int c = 0; c < 2; c++) begin
      enr[c][0] = 1'b1; rda[c][0] = 3'd2;
    end
    tick();
    idle();
    n_cmp++;
    if (qb0 !== 10'h2A5) begin
      n_bad++;
      $display("FAIL hold_read_b got %h want 2a5", qb0);
    end
    tick();
    n_cmp++;
    if (qa0 !== 10'h2A5 || va0 !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_on got q=%h v=%b want q=2a5 v=0", qa0, va0);
    end
    n_cmp++;
    if (qb0 !== 10'h000 || vb0 !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_off got q=%h v=%b want q=000 v=0", qb0, vb0);
    end
  endtask

  task automatic test_zero_range();
    idle();
    enw[1][0] = 1'b1; wra[1][0] = 3'd0; d[1][0] = 10'h1C3;
    tick();
    idle();
    enr[1][0] = 1'b1; rda[1][0] = 3'd0;
    tick();
    n_cmp++;
    if (qb0 !== 10'h000 || vb0 !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_reg got q=%h v=%b want q=000 v=1", qb0, vb0);
    end
    enw[1][1] = 1'b1; wra[1][1] = 3'd7; d[1][1] = 10'h3AA;
    rda[1][0] = 3'd7;
    tick();
    idle();
    n_cmp++;
    if (qb0 !== 10'h000 || vb0 !== 1'b1) begin
      n_bad++;
      $display("FAIL out_range got q=%h v=%b want q=000 v=1", qb0, vb0);
    end
    enw[1][0] = 1'b1; wra[1][0] = 3'd5; d[1][0] = 10'h00F;
    tick();
    idle();
    enr[1][0] = 1'b1; rda[1][0] = 3'd5;
    tick();
    idle();
    n_cmp++;
    if (qb0 !== 10'h00F) begin
      n_bad++;
      $display("FAIL top_addr got %h want 00f", qb0);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    enr[0][1] = 1'b1; rda[0][1] = 3'd1;
    tick();
    rst = 1'b1;
    enw[0][0] = 1'b1; wra[0][0] = 3'd1; d[0][0] = 10'h0AA;
    enr[0][1] = 1'b1; rda[0][1] = 3'd1;
    tick();
    n_cmp++;
    if (qa1 !== 10'h000 || va1 !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid got q=%h v=%b want q=000 v=0", qa1, va1);
    end
    idle();
    enr[0][1] = 1'b1; rda[0][1] = 3'd1;
    tick();
    idle();
    n_cmp++;
    if (qa1 !== 10'h000 || va1 !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_read got q=%h v=%b want q=000 v=1", qa1, va1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < 2; c++)
        for (int p = 0; p < 2; p++) begin
          enw[c][p] = $urandom_range(0, 1) == 1;
          enr[c][p] = $urandom_range(0, 3) != 0;
          d[c][p]   = 10'($urandom);
          wra[c][p] = 3'($urandom_range(0, c ? 7 : 3));
          rda[c][p] = 3'($urandom_range(0, c ? 7 : 3));
        end
      tick();
      for (int c = 0; c < 2; c++)
        for (int p = 0; p < 2; p++) begin
          n_cmp++;
          if (dq[c][p] !== eq[c][p] || dv[c][p] !== ev[c][p]) begin
            n_bad++;
            $display("FAIL rand cyc%0d dut%0d p%0d got q=%h v=%b want q=%h v=%b",
                     n, c, p, dq[c][p], dv[c][p], eq[c][p], ev[c][p]);
          end
        end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_collision();
    test_bypass();
    test_hold();
    test_zero_range();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_2w2r.md
Name: regfile_2w2r

Overview:
- Parametrised successor to the processor's 4 x 10-bit register file: DEPTH x WIDTH storage, two write ports, two read ports.
- Read outputs are registered, with optional write-to-read bypass, an optional hardwired-zero register 0, and per-port read-valid flags.
- Sits between the instruction decoder (addresses, enables) and the ALU/datapath mux.
- Default parameters give a drop-in superset of the existing 10-bit, 4-register file.

Parameters:
WIDTH, 10, data word width in bits
DEPTH, 4, number of registers (need not be a power of 2; minimum 2)
AW, $clog2(DEPTH), address width; a derived localparam, not overridable
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data is forwarded to a read of the same address
HOLD, 1, 1 = Qn holds its last value when ENRn is low; 0 = Qn is driven to 0

Ports:
Clkb  in  1  debounced system clock; all state updates on the rising edge
Rst  in  1  synchronous, active-high reset
D0  in  WIDTH  write data, port 0
WRA0  in  AW  write address, port 0
ENW0  in  1  write enable, port 0
D1  in  WIDTH  write data, port 1
WRA1  in  AW  write address, port 1
ENW1  in  1  write enable, port 1
RDA0  in  AW  read address, port 0
ENR0  in  1  read enable, port 0
RDA1  in  AW  read address, port 1
ENR1  in  1  read enable, port 1
Q0  out  WIDTH  read data, port 0 (registered)
Q1  out  WIDTH  read data, port 1 (registered)
V0  out  1  Q0 updated by a read on the last edge
V1  out  1  Q1 updated by a read on the last edge

Behaviour:
- Interface: one clock (Clkb); reset (Rst) is synchronous and active-high.
- Reset:
  - Rst sampled high at an edge clears all registers, Q0, Q1, V0 and V1 to 0.
  - Reset overrides any write or read in that cycle.
  - Asserting reset mid-operation simply discards that cycle's writes and reads.
- Writes:
  - If ENWn = 1 at an edge, reg[WRAn] <= Dn.
  - Both ports may write in the same cycle.
  - Same address on both ports: port 1 wins; port 0's data is dropped.
  - A write to an address >= DEPTH is ignored.
  - With ZERO_REG = 1, writes to address 0 are ignored.
- Reads:
  - Latency is 1 cycle. If ENRn = 1 at edge k, Qn shows the read data and Vn = 1 after edge k.
  - If ENRn = 0 at edge k, Vn = 0 after edge k. Qn holds (HOLD = 1) or goes to 0 (HOLD = 0).
  - A read of an address >= DEPTH returns 0, with Vn = 1.
  - With ZERO_REG = 1, a read of address 0 returns 0 regardless of bypass.
- Read-during-write to the same address in the same cycle:
  - BYPASS = 1: Qn gets the newly written data. If both write ports hit that address, Qn gets D1.
  - BYPASS = 0: Qn gets the pre-write contents.
- Both read ports may read the same address in the same cycle and receive identical data.
- There is no combinational path from any input to Q0, Q1, V0 or V1.
- No state machine is needed beyond the storage array and the output registers.

Decomposition:
- Package regfile_pkg holds:
  - function clog2_min1 (returns at least 1, so a DEPTH of 2 gives AW = 1);
  - the read-source select enum: SRC_ARRAY, SRC_BYP0, SRC_BYP1, SRC_ZERO.
- One sub-module, regfile_read_port, instantiated twice. It contains:
  - the address-range check and array mux;
  - the bypass compare against both write ports, with port 1 priority;
  - the output register plus valid flag;
  - the HOLD handling.
- The top level holds only the storage array, the write logic and the two sub-module instances.

Test Plan:
1. Reset and basic write/read (defaults): assert Rst 1 cycle → Q0 = Q1 = 0, V0 = V1 = 0. Then write ENW0 = 1, WRA0 = 2, D0 = 10'h2A5. Next cycle ENR0 = 1, RDA0 = 2 → one edge later Q0 = 10'h2A5, V0 = 1.
2. Dual-write collision: same cycle WRA0 = WRA1 = 1, D0 = 10'h111, D1 = 10'h222. Then read address 1 on both ports → Q0 = Q1 = 10'h222.
3. Bypass: reg3 holds 10'h055. Same cycle write reg3 = 10'h3FF on port 0 and read RDA1 = 3.
   - BYPASS = 1 → Q1 = 10'h3FF.
   - BYPASS = 0 → Q1 = 10'h055, then 10'h3FF on the next read.
4. HOLD and valid: read reg2 = 10'h2A5, then drop ENR0.
   - HOLD = 1 → Q0 stays 10'h2A5 with V0 = 0.
   - HOLD = 0 → Q0 = 0 with V0 = 0.
5. ZERO_REG and range (DEPTH = 6, ZERO_REG = 1): write 10'h1C3 to address 0 and read address 0 → Q0 = 0. Read address 7 → Q0 = 0, V0 = 1. Write address 5 = 10'h00F and read it back → 10'h00F.
6. Reset mid-operation: assert Rst in the same cycle as ENW0 = 1 (WRA0 = 1, D0 = 10'h0AA) and ENR1 = 1 → after the edge V1 = 0, Q1 = 0, and a later read of reg1 returns 0.
